// File: rtl/nes_pkg.sv
// Shared 6502 datapath definitions: register ids, transfer ops, status flag positions
// and the command legality rule used by the register-transfer sequencer.
package nes_pkg;

  localparam int BYTE       = 8;
  localparam int FLAG_N_BIT = 7;
  localparam int FLAG_Z_BIT = 1;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_X  = 3'd1,
    REG_Y  = 3'd2,
    REG_SP = 3'd3,
    REG_PC = 3'd4
  } reg_id_t;

  typedef enum logic [1:0] {
    OP_XFER = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2
  } xfer_op_t;

  function automatic logic is_gpr(input logic [2:0] id);
    return id <= 3'd3;
  endfunction

  // INC/DEC on SP has no 6502 opcode, so it is rejected even when inc/dec exists.
  function automatic logic cmd_legal(input logic [1:0] op, input logic [2:0] src,
                                     input logic [2:0] dst, input logic incdec_en);
    logic ok;
    ok = is_gpr(src);
    if (op == 2'd0)
      ok = ok && is_gpr(dst);
    else if (op == 2'd1 || op == 2'd2)
      ok = ok && incdec_en && (src != 3'd3);
    else
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/rf_xfer_calc.sv
// Combinational result/status calculation for the WRITE cycle.
// RF_XFER_INCDEC_EN builds the incrementer/decrementer; otherwise the result is the read data.
module rf_xfer_calc
  import nes_pkg::*;
#(
  parameter int DATA_W = BYTE
) (
  input  xfer_op_t          op,
  input  logic [DATA_W-1:0] data,
  input  logic [7:0]        status_i,
  output logic [DATA_W-1:0] res,
  output logic [7:0]        status_o
);

`ifdef RF_XFER_INCDEC_EN
  always_comb begin
    case (op)
      OP_INC:  res = data + DATA_W'(1);
      OP_DEC:  res = data - DATA_W'(1);
      default: res = data;
    endcase
  end
`else
  logic unused_op;
  assign unused_op = ^op;
  assign res       = data;
`endif

  always_comb begin
    status_o             = status_i;
    status_o[FLAG_N_BIT] = res[FLAG_N_BIT];
    status_o[FLAG_Z_BIT] = (res == '0);
  end

endmodule

// File: rtl/rf_xfer_seq.sv
// Register-file transfer sequencer: one RF read then one RF write per command, N/Z update on write.
// RF_XFER_INCDEC_EN enables INX/INY/DEX/DEY; without it those ops take the error path.
module rf_xfer_seq
  import nes_pkg::*;
#(
  parameter int DATA_W = BYTE,
  parameter int RF_W   = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [2:0]      cmd_src_i,
  input  logic [2:0]      cmd_dst_i,
  output logic            done_o,
  output logic            err_o,
  output logic [2:0]      rf_addr_o,
  output logic            rf_we_o,
  output logic [RF_W-1:0] rf_wdata_o,
  input  logic [RF_W-1:0] rf_rdata_i,
  output logic            status_we_o,
  output logic [7:0]      status_o,
  input  logic [7:0]      status_i
);

`ifdef RF_XFER_INCDEC_EN
  localparam logic INCDEC_EN = 1'b1;
`else
  localparam logic INCDEC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ERR} state_t;

  state_t            state_q, state_d;
  xfer_op_t          op_q;
  reg_id_t           src_q, dst_q;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic              accept, legal;
  logic [DATA_W-1:0] res;
  logic [7:0]        status_n;
  logic              unused_rdata_hi;

  assign accept          = cmd_valid_i && ready_q;
  assign legal           = cmd_legal(cmd_op_i, cmd_src_i, cmd_dst_i, INCDEC_EN);
  assign unused_rdata_hi = ^rf_rdata_i[RF_W-1:DATA_W];
  assign cmd_ready_o     = ready_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = legal ? S_READ : S_ERR;
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ready is registered so it stays low throughout reset and rises on the first edge after it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ready_q <= 1'b0;
      op_q    <= OP_XFER;
      src_q   <= REG_A;
      dst_q   <= REG_A;
      data_q  <= '0;
    end else begin
      ready_q <= (state_d == S_IDLE);
      if (accept) begin
        op_q  <= xfer_op_t'(cmd_op_i);
        src_q <= reg_id_t'(cmd_src_i);
        dst_q <= reg_id_t'(cmd_dst_i);
      end
      if (state_q == S_READ) data_q <= rf_rdata_i[DATA_W-1:0];
    end
  end

  rf_xfer_calc #(.DATA_W(DATA_W)) u_calc (
    .op       (op_q),
    .data     (data_q),
    .status_i (status_i),
    .res      (res),
    .status_o (status_n)
  );

  always_comb begin
    done_o      = 1'b0;
    err_o       = 1'b0;
    rf_addr_o   = 3'd0;
    rf_we_o     = 1'b0;
    rf_wdata_o  = '0;
    status_we_o = 1'b0;
    status_o    = 8'h00;
    case (state_q)
      S_READ: rf_addr_o = src_q;
      S_WRITE: begin
        rf_addr_o   = (op_q == OP_XFER) ? dst_q : src_q;
        rf_we_o     = 1'b1;
        rf_wdata_o  = {{(RF_W-DATA_W){1'b0}}, res};
        // TXS leaves the flags alone, every other write updates N/Z.
        status_we_o = !(op_q == OP_XFER && dst_q == REG_SP);
        status_o    = status_n;
        done_o      = 1'b1;
      end
      S_ERR: begin
        done_o = 1'b1;
        err_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_xfer_seq.sv
// Directed bench for rf_xfer_seq: transfers, flags, illegal commands, back-to-back and reset abort.
module tb_rf_xfer_seq;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [2:0]  cmd_src_i;
  logic [2:0]  cmd_dst_i;
  logic        done_o;
  logic        err_o;
  logic [2:0]  rf_addr_o;
  logic        rf_we_o;
  logic [15:0] rf_wdata_o;
  logic [15:0] rf_rdata_i;
  logic        status_we_o;
  logic [7:0]  status_o;
  logic [7:0]  status_i;
  logic [15:0] regs [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk_i = ~clk_i;
  assign rf_rdata_i = regs[rf_addr_o];

  rf_xfer_seq dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i),
    .done_o(done_o), .err_o(err_o),
    .rf_addr_o(rf_addr_o), .rf_we_o(rf_we_o), .rf_wdata_o(rf_wdata_o), .rf_rdata_i(rf_rdata_i),
    .status_we_o(status_we_o), .status_o(status_o), .status_i(status_i)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command in the current cycle T; returns at the negedge of T+1.
  task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_src_i   = src;
    cmd_dst_i   = dst;
    chk("ready_T", {15'd0, cmd_ready_o}, 16'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic err_path(input string tag, input logic [1:0] op, input logic [2:0] src,
                          input logic [2:0] dst);
    issue(op, src, dst);
    chk({tag, "_done"}, {15'd0, done_o}, 16'd1);
    chk({tag, "_err"},  {15'd0, err_o}, 16'd1);
    chk({tag, "_we1"},  {14'd0, rf_we_o, status_we_o}, 16'd0);
    @(negedge clk_i);
    chk({tag, "_we2"},  {14'd0, rf_we_o, status_we_o}, 16'd0);
    chk({tag, "_done2"}, {15'd0, done_o}, 16'd0);
    chk({tag, "_rdy"},  {15'd0, cmd_ready_o}, 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[0] = 16'h0080;
    rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_src_i = 3'd0; cmd_dst_i = 3'd0;
    status_i = 8'h24;

    repeat (2) @(negedge clk_i);
    chk("rst_ready", {15'd0, cmd_ready_o}, 16'd0);
    chk("rst_flags", {12'd0, done_o, err_o, rf_we_o, status_we_o}, 16'd0);
    chk("rst_addr",  {13'd0, rf_addr_o}, 16'd0);
    chk("rst_wdata", rf_wdata_o, 16'h0000);
    chk("rst_status", {8'd0, status_o}, 16'h0000);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {15'd0, cmd_ready_o}, 16'd1);

    // TAX, A=0x80, status 0x24
    issue(2'd0, 3'd0, 3'd1);
    chk("tax_rd_addr", {13'd0, rf_addr_o}, 16'd0);
    chk("tax_rd_we",   {15'd0, rf_we_o}, 16'd0);
    chk("tax_rd_rdy",  {15'd0, cmd_ready_o}, 16'd0);
    @(negedge clk_i);
    chk("tax_wr_addr", {13'd1 >> 0, rf_addr_o} & 16'h0007, 16'd1);
    chk("tax_wr_we",   {15'd0, rf_we_o}, 16'd1);
    chk("tax_wdata",   rf_wdata_o, 16'h0080);
    chk("tax_status",  {8'd0, status_o}, 16'h00A4);
    chk("tax_swe",     {15'd0, status_we_o}, 16'd1);
    chk("tax_done",    {14'd0, done_o, err_o}, 16'b10);
    @(negedge clk_i);
    chk("tax_next_rdy", {15'd0, cmd_ready_o}, 16'd1);
    chk("tax_next_done", {15'd0, done_o}, 16'd0);

    // TXS, X=0x00
    regs[1] = 16'h0000;
    issue(2'd0, 3'd1, 3'd3);
    @(negedge clk_i);
    chk("txs_addr",  {13'd0, rf_addr_o}, 16'd3);
    chk("txs_wdata", rf_wdata_o, 16'h0000);
    chk("txs_swe",   {15'd0, status_we_o}, 16'd0);
    chk("txs_we_done", {14'd0, rf_we_o, done_o}, 16'b11);

    // TYA, Y=0x00, status 0xFF -> Z set, N clear
    status_i = 8'hFF;
    issue(2'd0, 3'd2, 3'd0);
    @(negedge clk_i);
    chk("tya_addr",   {13'd0, rf_addr_o}, 16'd0);
    chk("tya_wdata",  rf_wdata_o, 16'h0000);
    chk("tya_status", {8'd0, status_o}, 16'h007F);
    chk("tya_swe",    {15'd0, status_we_o}, 16'd1);

    err_path("xfer_pc", 2'd0, 3'd4, 3'd0);
    err_path("xfer_dst7", 2'd0, 3'd0, 3'd7);
    err_path("op3", 2'd3, 3'd0, 3'd1);
    err_path("inc_sp", 2'd1, 3'd3, 3'd3);

`ifdef RF_XFER_INCDEC_EN
    status_i = 8'h00;
    regs[1] = 16'h00FF;
    issue(2'd1, 3'd1, 3'd0);
    chk("inx_rd_addr", {13'd0, rf_addr_o}, 16'd1);
    @(negedge clk_i);
    chk("inx_addr",   {13'd0, rf_addr_o}, 16'd1);
    chk("inx_wdata",  rf_wdata_o, 16'h0000);
    chk("inx_status", {8'd0, status_o}, 16'h0002);
    regs[2] = 16'h0000;
    issue(2'd2, 3'd2, 3'd0);
    @(negedge clk_i);
    chk("dey_addr",   {13'd0, rf_addr_o}, 16'd2);
    chk("dey_wdata",  rf_wdata_o, 16'h00FF);
    chk("dey_status", {8'd0, status_o}, 16'h0080);
`else
    err_path("inc_off", 2'd1, 3'd1, 3'd1);
    err_path("dec_off", 2'd2, 3'd2, 3'd2);
`endif

    // Two TAY commands with valid held high
    status_i = 8'h24;
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_src_i = 3'd0; cmd_dst_i = 3'd2;
    chk("b2b_rdy_T", {15'd0, cmd_ready_o}, 16'd1);
    @(negedge clk_i);
    chk("b2b_rdy_T1", {15'd0, cmd_ready_o}, 16'd0);
    @(negedge clk_i);
    chk("b2b_rdy_T2", {15'd0, cmd_ready_o}, 16'd0);
    chk("b2b_done_T2", {15'd0, done_o}, 16'd1);
    @(negedge clk_i);
    chk("b2b_rdy_T3", {15'd0, cmd_ready_o}, 16'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("b2b_rd_T4", {12'd0, cmd_ready_o, rf_addr_o}, 16'd0);
    @(negedge clk_i);
    chk("b2b_done_T5", {15'd0, done_o}, 16'd1);
    chk("b2b_wdata_T5", rf_wdata_o, 16'h0080);
    chk("b2b_addr_T5", {13'd0, rf_addr_o}, 16'd2);
    @(negedge clk_i);
    chk("b2b_idle_T6", {14'd0, cmd_ready_o, done_o}, 16'b10);

    // Reset pulse during READ
    issue(2'd0, 3'd0, 3'd1);
    chk("rstmid_read", {15'd0, rf_we_o}, 16'd0);
    rstn_i = 1'b0;
    #1;
    chk("rstmid_abort", {13'd0, cmd_ready_o, done_o, rf_we_o}, 16'd0);
    @(negedge clk_i);
    chk("rstmid_hold", {13'd0, cmd_ready_o, done_o, rf_we_o}, 16'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rstmid_release", {13'd0, cmd_ready_o, done_o, rf_we_o}, 16'b100);
    @(negedge clk_i);
    chk("rstmid_quiet", {12'd0, done_o, rf_we_o, status_we_o, err_o}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
